// File: rtl/mem_refill_responder.sv
// Backing-store responder for the data-cache miss path: accepts one refill or store at a time,
// models a fixed access latency and returns refill lines critical-word-first.
module mem_refill_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [ADDR_WIDTH-1:0] resp_addr,
   output logic                  resp_last,
   output logic                  resp_is_write,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count
);

   localparam int MW = $clog2(MEM_WORDS);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int LW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WACK} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [LW-1:0]         lat_q, lat_d;
   logic [OW-1:0]         idx_q, idx_d;
   logic [OW-1:0]         beat_q, beat_d;
   logic [31:0]           rcnt_q, rcnt_d;
   logic [31:0]           wcnt_q, wcnt_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   logic                  commit;
   logic [MW-1:0]         ridx;
   logic [MW-1:0]         widx;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wlane;

   assign ridx        = {addr_q[MW+1:OW+2], idx_q};
   assign widx        = addr_q[MW+1:2];
   assign read_count  = rcnt_q;
   assign write_count = wcnt_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      write_d       = write_q;
      size_d        = size_q;
      wdata_d       = wdata_q;
      lat_d         = lat_q;
      idx_d         = idx_q;
      beat_d        = beat_q;
      rcnt_d        = rcnt_q;
      wcnt_d        = wcnt_q;
      commit        = 1'b0;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_data     = '0;
      resp_addr     = '0;
      resp_last     = 1'b0;
      resp_is_write = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               write_d = req_write;
               size_d  = req_size;
               wdata_d = req_wdata;
               lat_d   = LW'(LATENCY);
               idx_d   = req_addr[OW+1:2];
               beat_d  = '0;
               if (req_write) wcnt_d = wcnt_q + 32'd1;
               else           rcnt_d = rcnt_q + 32'd1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            lat_d = lat_q - LW'(1);
            if (lat_q == LW'(1)) begin
               commit  = write_q;
               state_d = write_q ? S_WACK : S_BURST;
            end
         end
         S_BURST: begin
            resp_valid = 1'b1;
            resp_addr  = {addr_q[ADDR_WIDTH-1:OW+2], idx_q, 2'b00};
            resp_data  = mem_q[ridx];
            resp_last  = (beat_q == OW'(LINE_WORDS - 1));
            if (resp_ready) begin
               // Index wraps inside the aligned line by its own width.
               idx_d  = idx_q + OW'(1);
               beat_d = beat_q + OW'(1);
               if (resp_last) state_d = S_IDLE;
            end
         end
         S_WACK: begin
            resp_valid    = 1'b1;
            resp_is_write = 1'b1;
            resp_last     = 1'b1;
            resp_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      be    = 4'b1111;
      wlane = wdata_q;
      case (size_q)
         2'b00: begin
            be    = 4'b0001 << addr_q[1:0];
            wlane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lat_q   <= '0;
         rcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         rcnt_q  <= rcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
   end

   // Reset blocks the commit, so a store caught in WAIT by reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) mem_q[widx][8*l +: 8] <= wlane[8*l +: 8];
         end
      end
   end

endmodule

// File: doc/mem_refill_responder.md
Name: mem_refill_responder

Overview:
- Backing-store responder for the data-cache miss path; it is the memory end of the cache request/response protocol.
- Accepts one request at a time from the cache. Requests are line refills (reads) or single-word/sub-word stores.
- Holds an internal word-addressed memory array and models a fixed access latency.
- Returns refill lines critical-word-first, one beat per handshake, with back-pressure; reports read/write request counts.

Parameters:
- ADDR_WIDTH, 32, request address width in bits.
- DATA_WIDTH, 32, word width; fixed at 32 because byte-lane logic assumes 4 lanes.
- MEM_WORDS, 1024, memory depth in words; power of two.
- LINE_WORDS, 4, words per refill line; power of two, 2..16.
- LATENCY, 3, wait cycles between request acceptance and first response beat; must be >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = line refill.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  store size: 00 byte, 01 half, 10 word; 11 treated as word; ignored for refills.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  cache accepts the beat.
- resp_data  out  DATA_WIDTH  refill word; 0 on write acks.
- resp_addr  out  ADDR_WIDTH  word-aligned byte address of this beat.
- resp_last  out  1  final beat of the response.
- resp_is_write  out  1  beat is a store acknowledgement.
- read_count  out  32  accepted refill requests.
- write_count  out  32  accepted store requests.

Behaviour:
- States are IDLE, WAIT, BURST and WACK.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_addr=0, resp_last=0, resp_is_write=0, both counters 0, latency counter 0.
  - The memory array is not cleared by reset; its contents are undefined until written.
- Reset takes priority over all other activity.
  - Reset asserted mid-WAIT, BURST or WACK returns to IDLE on that edge.
  - Any uncommitted store is dropped; counters clear.
- IDLE:
  - req_ready=1 and resp_valid=0.
  - A handshake is req_valid && req_ready at an edge.
  - On a handshake the block captures addr, write, size and wdata; loads the latency counter with LATENCY; increments read_count or write_count; and moves to WAIT.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; when it reaches 1 the next edge leaves WAIT.
  - Result: first resp_valid is high in the cycle after edge k+LATENCY, where k is the acceptance edge.
  - A refill goes to BURST.
  - A store commits to memory on the WAIT-exit edge, then goes to WACK.
- BURST:
  - resp_valid=1 and req_ready=0.
  - The beat index starts at word offset addr[log2(LINE_WORDS)+1:2] (critical word first).
  - The index increments modulo LINE_WORDS within the aligned line.
  - resp_addr = line base | (index<<2); resp_data = mem[resp_addr word index].
  - The beat advances only on resp_valid && resp_ready. While resp_ready=0, all response outputs hold stable.
  - resp_last=1 on the LINE_WORDS-th beat. Its handshake returns to IDLE, and req_ready is 1 in the following cycle (no same-cycle re-accept).
- WACK:
  - Single beat: resp_valid=1, resp_is_write=1, resp_last=1, resp_data=0, resp_addr = request address with bits[1:0] cleared.
  - Holds until resp_ready, then goes to IDLE.
- Memory indexing: word index = addr[log2(MEM_WORDS)+1:2]; higher address bits are ignored (addresses alias modulo the memory size).
- Store lanes:
  - Byte: wdata[7:0] is written into lane addr[1:0].
  - Half: wdata[15:0] is written into lanes {addr[1],0}; addr[0] is ignored.
  - Word: the full word is written; addr[1:0] is ignored.
  - Unselected lanes are unchanged.
- Ordering: a refill accepted after a store ack observes the stored value, because requests are fully serialised.
- Counters wrap at 2^32 and do not saturate.

Test Plan:
- Reset and idle: hold rst 2 cycles -> req_ready=1, resp_valid=0, both counters 0. Release with no requests for 10 cycles -> outputs unchanged.
- Store then refill (LINE_WORDS=4, LATENCY=3):
  - Store words 0xA0,0xA1,0xA2,0xA3 to 0x10,0x14,0x18,0x1C; each ack arrives 3 cycles after acceptance with resp_is_write=1.
  - Then refill 0x18 -> beats (0x18,0xA2), (0x1C,0xA3), (0x10,0xA0), (0x14,0xA1); resp_last only on the 4th beat.
  - read_count=1, write_count=4.
- Sub-word stores: word store 0x11223344 to 0x20, byte store 0xEE to 0x21, half store 0xBEEF to 0x22; then refill 0x20 -> first beat data 0xBEEFEE44.
- Back-pressure: during a refill burst, drop resp_ready for 3 cycles on beat 2 -> resp_data, resp_addr and resp_last stay stable. Exactly 4 beats are accepted, and req_ready stays 0 until after the last beat.
- Reset mid-operation: assert rst while in WAIT for a store of 0xDEADBEEF to 0x40 -> IDLE next cycle, no ack. A later refill of 0x40 does not return 0xDEADBEEF (preload 0x0 at 0x40 first and expect 0x0).
- Aliasing: with MEM_WORDS=1024, store 0x55 (word) to 0x1000 -> a refill of 0x0 returns 0x55 as its first beat.
